// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the pipeline sequencer and the datapath/decoder.
// The slave side is the sequencer; the master side is the datapath and decoder.
interface pipeline_sequencer_if #(
    parameter int unsigned I = 32
);
    logic         start;
    logic         HaltD;
    logic         RegWriteD;
    logic         UseRA1D;
    logic         UseRA2D;
    logic [3:0]   RA1D;
    logic [3:0]   RA2D;
    logic [3:0]   WA3D;
    logic [I-1:0] PCF;
    logic         StallF;
    logic         StallD;
    logic         FlushD;
    logic         FlushE;
    logic         ValidD;
    logic         Busy;
    logic         Done;

    modport master (
        output start, HaltD, RegWriteD, UseRA1D, UseRA2D, RA1D, RA2D, WA3D,
        input  PCF, StallF, StallD, FlushD, FlushE, ValidD, Busy, Done
    );

    modport slave (
        input  start, HaltD, RegWriteD, UseRA1D, UseRA2D, RA1D, RA2D, WA3D,
        output PCF, StallF, StallD, FlushD, FlushE, ValidD, Busy, Done
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Run/halt controller and RAW-hazard scoreboard for the 5-stage vector pipeline.
// Drives fetch address and the IF/ID and ID/EX enable/flush controls.
module pipeline_sequencer #(
    parameter int unsigned  I       = 32,
    parameter int unsigned  NREG    = 16,
    parameter logic [I-1:0] PC_BASE = '0,
    parameter int unsigned  DRAIN   = 3
) (
    input logic                  clk,
    input logic                  reset,
    pipeline_sequencer_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int unsigned     CW         = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [CW-1:0]   DRAIN_LOAD = CW'(DRAIN - 1);

    logic [1:0]    r_state;
    logic [I-1:0]  r_pc;
    logic          r_valid;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_pend [NREG];

    logic w_run;
    logic w_start;
    logic w_src1_busy;
    logic w_src2_busy;
    logic w_hazard;
    logic w_halt_issue;
    logic w_issue;

    assign w_run        = (r_state == S_RUN);
    assign w_start      = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_src1_busy  = bus.UseRA1D && (r_pend[bus.RA1D] != 2'd0);
    assign w_src2_busy  = bus.UseRA2D && (r_pend[bus.RA2D] != 2'd0);
    assign w_hazard     = r_valid && (w_src1_busy || w_src2_busy);
    // Halt leaves ID as a bubble and never claims a destination register.
    assign w_halt_issue = w_run && r_valid && bus.HaltD && !w_hazard;
    assign w_issue      = w_run && r_valid && !w_hazard && bus.RegWriteD && !bus.HaltD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= PC_BASE;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_pc    <= PC_BASE;
                        r_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_halt_issue) begin
                        r_state <= S_DRAIN;
                        r_valid <= 1'b0;
                        r_cnt   <= DRAIN_LOAD;
                    end else if (!w_hazard) begin
                        r_pc    <= r_pc + I'(4);
                        r_valid <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A new issue to a register overrides its countdown in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (w_start) begin
                    r_pend[i] <= '0;
                end else if (w_issue && (bus.WA3D == i[3:0])) begin
                    r_pend[i] <= 2'd2;
                end else if (r_pend[i] != 2'd0) begin
                    r_pend[i] <= r_pend[i] - 2'd1;
                end
            end
        end
    end

    assign bus.PCF    = r_pc;
    assign bus.StallF = w_hazard;
    assign bus.StallD = w_hazard;
    assign bus.FlushD = w_halt_issue;
    assign bus.FlushE = w_hazard || w_halt_issue;
    assign bus.ValidD = r_valid;
    assign bus.Busy   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.Done   = (r_state == S_DONE);

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench: a cycle-indexed reference model (register ready times,
// fetch PC, drain end cycle) predicts every output of the sequencer each cycle.
module tb_pipeline_sequencer;

    localparam int unsigned DR   = 3;
    localparam logic [31:0] PC0  = 32'h0;
    localparam logic [31:0] WPC0 = 32'hFFFF_FFF8;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    typedef struct packed {
        logic       halt;
        logic       rw;
        logic [3:0] wa;
        logic       u1;
        logic [3:0] a1;
        logic       u2;
        logic [3:0] a2;
    } instr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_sequencer_if #(.I(32)) bus ();
    pipeline_sequencer_if #(.I(32)) wbus ();

    pipeline_sequencer #(.I(32), .NREG(16), .PC_BASE(PC0), .DRAIN(DR)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    pipeline_sequencer #(.I(32), .NREG(16), .PC_BASE(WPC0), .DRAIN(DR)) u_wrap (
        .clk(clk), .reset(reset), .bus(wbus.slave)
    );

    instr_t      rom [64];
    int          ntests = 0;
    int          nfail  = 0;
    int          cyc    = 0;
    int          mode;
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    bit          m_valid;
    int          ready_at [16];
    int          done_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(bit h, bit rw, int wa, bit u1, int a1, bit u2, int a2);
        instr_t r;
        r.halt = h;    r.rw = rw;    r.wa = 4'(wa);
        r.u1   = u1;   r.a1 = 4'(a1);
        r.u2   = u2;   r.a2 = 4'(a2);
        return r;
    endfunction

    function automatic instr_t nop();
        return mk(0, 0, $urandom_range(0, 15), 0, $urandom_range(0, 15), 0, $urandom_range(0, 15));
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = nop();
    endtask

    task automatic model_reset();
        mode    = M_IDLE;
        m_pc    = PC0;
        m_id_pc = '0;
        m_valid = 0;
        for (int r = 0; r < 16; r++) ready_at[r] = 0;
    endtask

    // One clock: present the instruction the model says is in ID, check, advance.
    task automatic cycle(input bit st, output bit stalled);
        instr_t      ins;
        logic [31:0] rnd;
        bit          run, hz, hiss, iss;
        if (m_valid) begin
            ins = rom[m_id_pc[7:2]];
        end else begin
            rnd = $urandom;
            ins = rnd[$bits(instr_t)-1:0];
        end
        bus.start     = st;
        bus.HaltD     = ins.halt;
        bus.RegWriteD = ins.rw;
        bus.WA3D      = ins.wa;
        bus.UseRA1D   = ins.u1;
        bus.RA1D      = ins.a1;
        bus.UseRA2D   = ins.u2;
        bus.RA2D      = ins.a2;
        #1;
        run  = (mode == M_RUN);
        hz   = run && m_valid && ((ins.u1 && cyc < ready_at[ins.a1]) ||
                                  (ins.u2 && cyc < ready_at[ins.a2]));
        hiss = run && m_valid && ins.halt && !hz;
        iss  = run && m_valid && !hz && ins.rw && !ins.halt;
        chk("PCF",    bus.PCF, m_pc);
        chk("StallF", 32'(bus.StallF), 32'(hz));
        chk("StallD", 32'(bus.StallD), 32'(hz));
        chk("FlushE", 32'(bus.FlushE), 32'(hz || hiss));
        chk("FlushD", 32'(bus.FlushD), 32'(hiss));
        chk("ValidD", 32'(bus.ValidD), 32'(m_valid));
        chk("Busy",   32'(bus.Busy),   32'(mode == M_RUN || mode == M_DRAIN));
        chk("Done",   32'(bus.Done),   32'(mode == M_DONE));
        stalled = bus.StallF;
        if (iss) ready_at[ins.wa] = cyc + 3;
        case (mode)
            M_IDLE, M_DONE: if (st) begin
                mode    = M_RUN;
                m_pc    = PC0;
                m_valid = 0;
                for (int r = 0; r < 16; r++) ready_at[r] = 0;
            end
            M_RUN: if (hiss) begin
                mode    = M_DRAIN;
                m_valid = 0;
                done_at = cyc + DR + 1;
            end else if (!hz) begin
                m_id_pc = m_pc;
                m_pc    = m_pc + 32'd4;
                m_valid = 1;
            end
            M_DRAIN: if (cyc + 1 == done_at) mode = M_DONE;
            default: ;
        endcase
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_prog(input string name, input int exp_stalls, input bit noise);
        bit s;
        bit got_done = 0;
        int stalls   = 0;
        cycle(1, s);
        for (int k = 0; k < 300; k++) begin
            cycle(noise ? bit'($urandom_range(0, 1)) : 1'b0, s);
            if (s) stalls++;
            if (bus.Done) begin
                got_done = 1;
                break;
            end
        end
        chk({name, "_reached_done"}, 32'(got_done), 32'd1);
        if (exp_stalls >= 0) chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    endtask

    initial begin
        logic [31:0] wexp [4];
        bit          s;

        reset = 1'b1;
        bus.start = 0;  bus.HaltD = 0; bus.RegWriteD = 0; bus.UseRA1D = 0; bus.UseRA2D = 0;
        bus.RA1D  = '0; bus.RA2D  = '0; bus.WA3D = '0;
        wbus.start = 0; wbus.HaltD = 0; wbus.RegWriteD = 0; wbus.UseRA1D = 0; wbus.UseRA2D = 0;
        wbus.RA1D  = '0; wbus.RA2D = '0; wbus.WA3D = '0;
        model_reset();
        clear_rom();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // PC wrap on the second instance; main DUT stays idle meanwhile.
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0; wexp[3] = 32'h4;
        wbus.start = 1;
        for (int k = 0; k < 4; k++) begin
            cycle(0, s);
            wbus.start = 0;
            chk("wrap_PCF", wbus.PCF, wexp[k]);
        end

        // Reset mid-run with r3 pending.
        clear_rom();
        rom[0]  = mk(0, 1, 3, 0, 0, 0, 0);
        rom[10] = mk(1, 0, 0, 0, 0, 0, 0);
        cycle(1, s);
        cycle(0, s);
        cycle(0, s);
        cycle(0, s);
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_PCF",    bus.PCF, PC0);
        chk("rst_ValidD", 32'(bus.ValidD), 32'd0);
        chk("rst_Busy",   32'(bus.Busy),   32'd0);
        chk("rst_Done",   32'(bus.Done),   32'd0);
        chk("rst_FlushE", 32'(bus.FlushE), 32'd0);
        chk("rst_StallF", 32'(bus.StallF), 32'd0);
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b0;

        clear_rom();
        rom[0] = mk(0, 0, 0, 1, 3, 0, 0);
        rom[2] = mk(1, 0, 0, 0, 0, 0, 0);
        run_prog("post_reset", 0, 0);

        clear_rom();
        rom[0] = mk(0, 1, 5, 0, 0, 0, 0);
        rom[1] = mk(0, 0, 0, 1, 5, 0, 0);
        rom[2] = mk(1, 0, 0, 0, 0, 0, 0);
        run_prog("raw_d1", 2, 0);

        clear_rom();
        rom[0] = mk(0, 1, 2, 0, 0, 0, 0);
        rom[2] = mk(0, 0, 0, 0, 0, 1, 2);
        rom[3] = mk(1, 0, 0, 0, 0, 0, 0);
        run_prog("raw_d2", 1, 0);

        clear_rom();
        rom[0] = mk(0, 1, 2, 0, 0, 0, 0);
        rom[3] = mk(0, 0, 0, 0, 0, 1, 2);
        rom[4] = mk(1, 0, 0, 0, 0, 0, 0);
        run_prog("raw_d3", 0, 0);

        clear_rom();
        rom[0] = mk(0, 1, 2, 0, 0, 0, 0);
        rom[2] = mk(0, 0, 0, 0, 0, 0, 2);
        rom[3] = mk(1, 0, 0, 0, 0, 0, 0);
        run_prog("no_use_ra2", 0, 0);

        clear_rom();
        rom[0] = mk(0, 1, 7, 0, 0, 0, 0);
        rom[1] = mk(0, 1, 7, 0, 0, 0, 0);
        rom[2] = mk(0, 0, 0, 1, 7, 0, 0);
        rom[3] = mk(1, 0, 0, 0, 0, 0, 0);
        run_prog("reissue_r7", 2, 0);

        clear_rom();
        rom[0] = mk(0, 1, 1, 0, 0, 0, 0);
        rom[1] = mk(1, 0, 0, 1, 1, 0, 0);
        run_prog("halt_hazard", 2, 0);

        for (int p = 0; p < 6; p++) begin
            clear_rom();
            for (int i = 0; i < 16; i++) begin
                rom[i] = mk(0, bit'($urandom_range(0, 1)), $urandom_range(0, 3),
                            bit'($urandom_range(0, 1)), $urandom_range(0, 3),
                            bit'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
            rom[16] = mk(1, bit'($urandom_range(0, 1)), $urandom_range(0, 3), 0, 0, 0, 0);
            run_prog("random", -1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
